// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// with valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// BUSY  | shifting one bit per clock through the full-subtractor cell
// DONE  | result held with out_valid high until out_ready
module serial_subtractor #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         borrow_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         borrow_out,
   output logic         overflow,
   output logic         zero
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic          a_msb;
   logic          b_msb;
   logic          br;
   logic          d;
   logic          br_next;
   logic [N-1:0]  diff_next;

   // Operands shift right so the cell always sees bit 0; diff fills from the top.
   assign d         = a_sh[0] ^ b_sh[0] ^ br;
   assign br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign diff_next = {d, diff[N-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         idx        <= '0;
         br         <= 1'b0;
         a_sh       <= '0;
         b_sh       <= '0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  a_msb    <= a[N-1];
                  b_msb    <= b[N-1];
                  br       <= borrow_in;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_next;
               diff <= diff_next;
               idx  <= idx + 1'b1;
               if (idx == IW'(N - 1)) begin
                  borrow_out <= br_next;
                  overflow   <= (a_msb != b_msb) && (d != a_msb);
                  zero       <= (diff_next == '0);
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=8 against a word-level reference.
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a_i = '0;
   logic [N-1:0] b_i = '0;
   logic         bin_i = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] diff;
   logic         borrow_out;
   logic         overflow;
   logic         zero;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .borrow_in (bin_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow_out(borrow_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       ov;
      logic       z;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present operands, wait for acceptance and measure edges until out_valid.
   task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                           output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_idle", in_ready, 1);
      a_i = ta; b_i = tb; bin_i = tbin; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a_i = ~ta; b_i = ta ^ 8'h5A; bin_i = ~tbin;
      chk("in_ready_busy", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string name, input logic [7:0] ed, input logic ebo,
                               input logic eov, input logic ez);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_diff"}, diff, ed);
      chk({name, "_borrow"}, borrow_out, ebo);
      chk({name, "_ovf"}, overflow, eov);
      chk({name, "_zero"}, zero, ez);
   endtask

   // Hold out_ready low for stall cycles, then complete the output handshake.
   task automatic finish_op(input int stall, input logic [7:0] ed);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_diff", diff, ed);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("done_valid_low", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
   endtask

   initial begin
      int lat;
      logic [8:0] ref_w;
      logic [7:0] ra, rb, rd;
      logic rbin, rov;

      vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};

      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_zero", zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
         chk("vec_latency", lat, N);
         check_result("vec", vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z);
         finish_op(0, vecs[i].d);
      end

      // Backpressure with an ignored in_valid pulse during the stall.
      start_op(8'h35, 8'h12, 1'b0, lat);
      chk("bp_latency", lat, N);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            a_i = 8'hAA; b_i = 8'h11; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_diff", diff, 8'h23);
      end
      in_valid = 1'b0;
      check_result("bp", 8'h23, 1'b0, 1'b0, 1'b0);
      finish_op(0, 8'h23);
      @(negedge clk);
      chk("bp_idle_hold", out_valid, 0);

      // Asynchronous reset in the middle of BUSY.
      a_i = 8'h35; b_i = 8'h12; bin_i = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_diff", diff, 0);
      chk("arst_borrow", borrow_out, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_zero", zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(8'h05, 8'h03, 1'b0, lat);
      chk("arst_next_latency", lat, N);
      check_result("arst_next", 8'h02, 1'b0, 1'b0, 1'b0);
      finish_op(0, 8'h02);

      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rbin = 1'($urandom);
         ref_w = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
         rd = ref_w[7:0];
         rov = (ra[7] != rb[7]) && (rd[7] != ra[7]);
         start_op(ra, rb, rbin, lat);
         chk("rand_latency", lat, N);
         check_result("rand", rd, ref_w[8], rov, rd == 8'h00);
         finish_op(int'($urandom_range(0, 3)), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - borrow_in, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow chain. It is the inverse of the ripple-carry add path and targets area-constrained ALU variants. The block accepts operands over a valid/ready input handshake and presents results over a valid/ready output handshake.

Parameters:
N, 32, operand and result width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, borrow_in are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  minuend
b  input  N  subtrahend
borrow_in  input  1  initial borrow into bit 0
out_valid  output  1  result fields are valid
out_ready  input  1  consumer accepts the result
diff  output  N  a - b - borrow_in, modulo 2^N
borrow_out  output  1  borrow out of bit N-1 (1 means the unsigned result underflowed)
overflow  output  1  signed two's-complement overflow
zero  output  1  diff == 0

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- States: IDLE, BUSY, DONE.
- Reset (asynchronous, rst_n low): state = IDLE, in_ready = 1, out_valid = 0, diff = 0, borrow_out = 0, overflow = 0, zero = 0, bit index = 0, internal borrow = 0. Reset in BUSY or DONE aborts the operation and discards the result.
- IDLE: in_ready = 1. On the rising edge where in_valid && in_ready:
  - latch a, b, and borrow_in into the internal borrow register;
  - clear the index;
  - go to BUSY.
  - In the same cycle in_ready falls and out_valid stays 0.
- BUSY: in_ready = 0. On each edge, for bit i = index:
  - d_i = a_i ^ b_i ^ br;
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  - store d_i at diff bit i; index increments.
  - After the edge that processes bit N-1, go to DONE.
  - Input handshakes are ignored while in BUSY.
- Latency: the operation is accepted at edge T. Bits are processed at edges T+1 through T+N. out_valid is high from edge T+N onward. Throughput is at most one operation per N+2 cycles.
- DONE: out_valid = 1. The following outputs are registered and stable while out_valid is high:
  - diff;
  - borrow_out = final br;
  - overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), using the latched a and b;
  - zero = (diff == 0).
  - On the edge where out_valid && out_ready, go to IDLE and drop out_valid. in_ready rises in that same cycle.
  - If out_ready is held low, the result is held indefinitely.
- Outputs are not cleared on return to IDLE; only out_valid qualifies them.
- Wrap-around: results are modulo 2^N. borrow_out reports unsigned underflow (a < b + borrow_in).
- Simultaneous events: in_valid asserted during BUSY or DONE has no effect. The producer must hold in_valid until in_ready. A new acceptance is possible from the cycle after the output handshake.
- The operand registers are internal copies, so changing a and b after acceptance does not affect the result.

Test Plan:
- N=8, a=0x35, b=0x12, borrow_in=0 -> after 8 cycles: diff=0x23, borrow_out=0, overflow=0, zero=0.
- N=8, a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1, overflow=0; a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, zero=1, borrow_out=0.
- N=8, a=0x80, b=0x01 -> diff=0x7F, overflow=1; a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrow_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> diff stays stable and in_ready stays 0. Pulse in_valid with new operands during the stall -> ignored. Raise out_ready -> IDLE, in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 at cycle 4 of BUSY -> all outputs zero and in_ready=1 immediately (asynchronously). The next operation a=0x05, b=0x03 yields diff=0x02.
- Back-to-back random: 1000 random operand/borrow triples with random out_ready -> every result matches the reference model, and each measured latency equals N edges from acceptance to out_valid.
